// File: rtl/counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | counter_pkg: shared types for the counter command scheduler          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package counter_pkg;

    localparam int DW = 8;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter: combinational round-robin pick starting at ptr           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 any_grant
);

    localparam int IW = $clog2(N);

    logic [IW:0] pos;

    // Walk offsets from farthest to nearest so the requester closest to ptr wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        pos       = '0;
        for (int i = N - 1; i >= 0; i--) begin
            pos = {1'b0, ptr} + (IW + 1)'(i);
            if (pos >= (IW + 1)'(N)) begin
                pos = pos - (IW + 1)'(N);
            end
            if (req[pos[IW-1:0]]) begin
                grant                = '0;
                grant[pos[IW-1:0]]   = 1'b1;
                grant_idx            = pos[IW-1:0];
                any_grant            = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/counter_cmd_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | counter_cmd_sched: round-robin command scheduler for a shared counter|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module counter_cmd_sched
    import counter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int RW   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [2*NREQ-1:0]        req_op,
    input  logic [DW*NREQ-1:0]       req_data,
    input  logic [RW*NREQ-1:0]       req_rpt,
    input  logic [DW-1:0]            cnt_q,
    output logic [1:0]               cnt_c,
    output logic [DW-1:0]            cnt_din,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(NREQ)-1:0]  done_id,
    output logic [DW-1:0]            result
);

    localparam int IDW = $clog2(NREQ);

    state_e           state;
    state_e           state_nxt;
    op_e              op_q;
    logic [DW-1:0]    data_q;
    logic [RW-1:0]    rpt_cnt;
    logic [IDW-1:0]   id_q;
    logic [IDW-1:0]   rr_ptr;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    logic             any_grant;

    logic [1:0]       op_arr   [NREQ];
    logic [DW-1:0]    data_arr [NREQ];
    logic [RW-1:0]    rpt_arr  [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign op_arr[g]   = req_op[2*g +: 2];
        assign data_arr[g] = req_data[DW*g +: DW];
        assign rpt_arr[g]  = req_rpt[RW*g +: RW];
    end

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // Outside RUN the counter is held by reloading its own output.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        cnt_c     = OP_LOAD;
        cnt_din   = cnt_q;
        busy      = (state != IDLE);
        done      = 1'b0;
        done_id   = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (any_grant) begin
                        req_ready = grant;
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    cnt_c   = op_q;
                    cnt_din = data_q;
                    if (rpt_cnt == '0) begin
                        state_nxt = DONE;
                    end
                end
                DONE: begin
                    done      = 1'b1;
                    done_id   = id_q;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            result  <= '0;
            id_q    <= '0;
            op_q    <= OP_LOAD;
            data_q  <= '0;
            rpt_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any_grant) begin
                        op_q    <= op_e'(op_arr[grant_idx]);
                        data_q  <= data_arr[grant_idx];
                        rpt_cnt <= rpt_arr[grant_idx];
                        id_q    <= grant_idx;
                        rr_ptr  <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                    end
                end
                RUN:     rpt_cnt <= rpt_cnt - 1'b1;
                DONE:    result  <= cnt_q;
                default: ;
            endcase
        end
    end

endmodule : counter_cmd_sched
`default_nettype wire
